// File: rtl/sc_lut_pkg.sv
// Shared constants and pipeline tag type for the sine/cosine LUT scheduler.
package sc_lut_pkg;

  localparam int ASZ_DEF     = 10;
  localparam int DSZ_DEF     = 18;
  localparam int LUT_LAT_DEF = 2;
  localparam int QUARTER     = 2 ** (ASZ_DEF - 2);
  localparam int IDW_MAX     = 4;

  typedef struct packed {
    logic               valid;
    logic [IDW_MAX-1:0] id;
  } tag_t;

endpackage

// File: rtl/sc_lut_sched_rr_arb.sv
// Round-robin one-hot arbiter: search starts at ptr, masked requesters are skipped,
// and ptr moves past the winner.
module rr_arb
  import sc_lut_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_vld
);

  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] elig;

  assign elig = req & ~mask;

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_vld && elig[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
        gnt_vld  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

endmodule

// File: rtl/sc_lut_sched.sv
// Shares one dual-port sine/cosine LUT between NREQ voices; results come back
// tagged with the voice id, LUT_LAT+2 cycles after the grant edge.
module sc_lut_sched
  import sc_lut_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ASZ     = ASZ_DEF,
  parameter int DSZ     = DSZ_DEF,
  parameter int LUT_LAT = LUT_LAT_DEF,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*ASZ-1:0] phase,
  output logic [NREQ-1:0]     ack,
  output logic [ASZ-1:0]      lut_a0,
  output logic [ASZ-1:0]      lut_a1,
  input  logic [DSZ-1:0]      lut_d0,
  input  logic [DSZ-1:0]      lut_d1,
  output logic                rd_valid,
  output logic [IDW-1:0]      rd_id,
  output logic [DSZ-1:0]      rd_sin,
  output logic [DSZ-1:0]      rd_cos
);

  localparam logic [ASZ-1:0] QTR = ASZ'(2 ** (ASZ - 2));

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_vld;
  logic [ASZ-1:0]  ph_sel;
  tag_t            tag_pipe [LUT_LAT+1];

  // The voice acked this cycle is masked so a late req drop cannot double-grant.
  rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .mask    (ack),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  assign ph_sel = phase[int'(gnt_id)*ASZ +: ASZ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack      <= '0;
      lut_a0   <= '0;
      lut_a1   <= '0;
      rd_valid <= 1'b0;
      rd_id    <= '0;
      rd_sin   <= '0;
      rd_cos   <= '0;
      for (int i = 0; i <= LUT_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      ack <= gnt;
      if (gnt_vld) begin
        lut_a0 <= ph_sel;
        lut_a1 <= ph_sel + QTR;
      end
      tag_pipe[0] <= tag_t'{valid: gnt_vld, id: IDW_MAX'(gnt_id)};
      for (int i = 1; i <= LUT_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      // Last tag stage lines up with LUT data valid.
      rd_valid <= tag_pipe[LUT_LAT].valid;
      if (tag_pipe[LUT_LAT].valid) begin
        rd_id  <= tag_pipe[LUT_LAT].id[IDW-1:0];
        rd_sin <= lut_d0;
        rd_cos <= lut_d1;
      end
    end
  end

endmodule

// File: tb/tb_sc_lut_sched.sv
// Directed bench for sc_lut_sched with a behavioural 2-cycle LUT model.
module tb_sc_lut_sched;

  localparam int NREQ = 4;
  localparam int ASZ  = 10;
  localparam int DSZ  = 18;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*ASZ-1:0] phase = '0;
  logic [NREQ-1:0]     ack;
  logic [ASZ-1:0]      lut_a0, lut_a1;
  logic [DSZ-1:0]      lut_d0 = '0, lut_d1 = '0;
  logic                rd_valid;
  logic [IDW-1:0]      rd_id;
  logic [DSZ-1:0]      rd_sin, rd_cos;

  logic [ASZ-1:0]      a0_q = '0, a1_q = '0;
  logic [ASZ-1:0]      ph_tab [NREQ];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sc_lut_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .phase    (phase),
    .ack      (ack),
    .lut_a0   (lut_a0),
    .lut_a1   (lut_a1),
    .lut_d0   (lut_d0),
    .lut_d1   (lut_d1),
    .rd_valid (rd_valid),
    .rd_id    (rd_id),
    .rd_sin   (rd_sin),
    .rd_cos   (rd_cos)
  );

  function automatic logic [DSZ-1:0] f_sin(input logic [ASZ-1:0] a);
    return {a, 8'h5A};
  endfunction

  function automatic logic [DSZ-1:0] f_cos(input logic [ASZ-1:0] a);
    return {~a, 8'hC3};
  endfunction

  // LUT model: address register then BRAM read register.
  always @(posedge clk) begin
    a0_q   <= lut_a0;
    a1_q   <= lut_a1;
    lut_d0 <= f_sin(a0_q);
    lut_d1 <= f_cos(a1_q);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ph(input int v, input logic [ASZ-1:0] p);
    phase[v*ASZ +: ASZ] = p;
    ph_tab[v] = p;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},    32'(ack),      32'h0);
    chk({tag, "_a0"},     32'(lut_a0),   32'h0);
    chk({tag, "_a1"},     32'(lut_a1),   32'h0);
    chk({tag, "_rdv"},    32'(rd_valid), 32'h0);
    chk({tag, "_rdid"},   32'(rd_id),    32'h0);
    chk({tag, "_rdsin"},  32'(rd_sin),   32'h0);
    chk({tag, "_rdcos"},  32'(rd_cos),   32'h0);
  endtask

  initial begin
    logic [ASZ-1:0] ca;
    int id;
    for (int v = 0; v < NREQ; v++) ph_tab[v] = '0;

    // reset state
    step();
    chk_all_zero("rst");
    rst_n = 1'b1;
    step();

    // single voice 2, phase 0
    set_ph(2, 10'h000);
    req = 4'b0100;
    step();
    chk("t1_ack", 32'(ack), 32'h4);
    chk("t1_a0", 32'(lut_a0), 32'h000);
    chk("t1_a1", 32'(lut_a1), 32'h100);
    req = 4'b0000;
    step();
    chk("t1_ack_off", 32'(ack), 32'h0);
    step();
    chk("t1_rdv_early", 32'(rd_valid), 32'h0);
    step();
    chk("t1_rdv", 32'(rd_valid), 32'h1);
    chk("t1_rdid", 32'(rd_id), 32'h2);
    chk("t1_sin", 32'(rd_sin), 32'(f_sin(10'h000)));
    chk("t1_cos", 32'(rd_cos), 32'(f_cos(10'h100)));
    step();
    chk("t1_rdv_off", 32'(rd_valid), 32'h0);
    chk("t1_sin_hold", 32'(rd_sin), 32'(f_sin(10'h000)));

    // quarter-turn wrap on voice 1
    set_ph(1, 10'h3FF);
    req = 4'b0010;
    step();
    chk("t2_ack", 32'(ack), 32'h2);
    chk("t2_a0", 32'(lut_a0), 32'h3FF);
    chk("t2_a1", 32'(lut_a1), 32'h0FF);
    req = 4'b0000;
    repeat (3) step();
    chk("t2_rdv", 32'(rd_valid), 32'h1);
    chk("t2_rdid", 32'(rd_id), 32'h1);
    chk("t2_sin", 32'(rd_sin), 32'(f_sin(10'h3FF)));
    chk("t2_cos", 32'(rd_cos), 32'(f_cos(10'h0FF)));

    // after a grant to 2, voices 1 and 3 together: 3 first, then 1
    set_ph(2, 10'h155);
    set_ph(3, 10'h2AA);
    req = 4'b0100;
    step();
    chk("t4_ack2", 32'(ack), 32'h4);
    req = 4'b1010;
    step();
    chk("t4_ack3", 32'(ack), 32'h8);
    req = 4'b0010;
    step();
    chk("t4_ack1", 32'(ack), 32'h2);
    req = 4'b0000;
    step();
    chk("t4_rd0_v", 32'(rd_valid), 32'h1);
    chk("t4_rd0_id", 32'(rd_id), 32'h2);
    chk("t4_rd0_sin", 32'(rd_sin), 32'(f_sin(10'h155)));
    step();
    chk("t4_rd1_v", 32'(rd_valid), 32'h1);
    chk("t4_rd1_id", 32'(rd_id), 32'h3);
    chk("t4_rd1_cos", 32'(rd_cos), 32'(f_cos(10'h3AA)));
    step();
    chk("t4_rd2_v", 32'(rd_valid), 32'h1);
    chk("t4_rd2_id", 32'(rd_id), 32'h1);
    chk("t4_rd2_sin", 32'(rd_sin), 32'(f_sin(10'h3FF)));
    step();
    chk("t4_rd_end", 32'(rd_valid), 32'h0);

    // lone voice 0: ack every other cycle
    req = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("t5_ack_c%0d", k), 32'(ack), (k % 2 == 1) ? 32'h1 : 32'h0);
    end
    req = 4'b0000;
    repeat (5) step();

    // all voices requesting from reset
    rst_n = 1'b0;
    set_ph(0, 10'h010);
    set_ph(1, 10'h123);
    set_ph(2, 10'h2F0);
    set_ph(3, 10'h3C0);
    req = 4'b1111;
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("t3_ack_c%0d", k), 32'(ack), 32'h1 << ((k - 1) % 4));
      if (k >= 4) begin
        id = (k - 4) % 4;
        ca = ph_tab[id] + 10'h100;
        chk($sformatf("t3_rdv_c%0d", k), 32'(rd_valid), 32'h1);
        chk($sformatf("t3_rdid_c%0d", k), 32'(rd_id), 32'(id));
        chk($sformatf("t3_sin_c%0d", k), 32'(rd_sin), 32'(f_sin(ph_tab[id])));
        chk($sformatf("t3_cos_c%0d", k), 32'(rd_cos), 32'(f_cos(ca)));
      end else begin
        chk($sformatf("t3_rdv_c%0d", k), 32'(rd_valid), 32'h0);
      end
    end

    // reset with results in flight
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("t6_ack_c%0d", k), 32'(ack), 32'h1 << ((k - 1) % 4));
      chk($sformatf("t6_rdv_c%0d", k), 32'(rd_valid), (k >= 4) ? 32'h1 : 32'h0);
    end
    chk("t6_rdid", 32'(rd_id), 32'h0);
    chk("t6_sin", 32'(rd_sin), 32'(f_sin(10'h010)));
    req = 4'b0000;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
